// File: rtl/fetch_pair_queue.sv
// fetch_pair_queue: dual-issue fetch front end ahead of ID.
// Issues one aligned pair request at a time, buffers returned pairs in a
// small FIFO and presents the head pair with its PC+8. A redirect flushes
// the FIFO and discards any response still in flight.
module fetch_pair_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     im_req,
  output logic [31:0]              im_addr,
  input  logic                     im_ack,
  input  logic [31:0]              im_data,
  input  logic [31:0]              im_data1,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     hold,
  output logic                     out_valid,
  output logic [31:0]              out_inst,
  output logic [31:0]              out_inst1,
  output logic [31:0]              out_pc8,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  logic [31:0]   fifo_inst  [DEPTH];
  logic [31:0]   fifo_inst1 [DEPTH];
  logic [31:0]   fifo_pc8   [DEPTH];

  logic          pop;
  logic          push;
  logic          room;
  logic          req_raw;
  logic [CW-1:0] count_less_pop;
  logic [CW-1:0] count_next;

  // Low address bits of a redirect target are ignored by design.
  logic          redirect_pc_unused;
  assign redirect_pc_unused = ^redirect_pc[2:0];

  // Queue bookkeeping: pop/push qualification and occupancy look-ahead.
  always_comb begin
    pop            = out_valid & ~hold & ~redirect;
    push           = (state == WAIT) & im_ack & ~redirect;
    count_less_pop = count - CW'(pop);
    count_next     = count_less_pop + CW'(push);
    room           = (state == WAIT) ? (count_next < DEPTH_C)
                                     : (count_less_pop < DEPTH_C);
  end

  // Next-state and request generation.
  // In DROP an arriving ack always retires the stale request, even when a
  // redirect lands in the same cycle; staying in DROP there would wait for
  // an ack that never comes. The redirect still updates fetch_pc.
  always_comb begin
    state_next = state;
    req_raw    = 1'b0;
    case (state)
      IDLE: begin
        if (!redirect && room) begin
          req_raw    = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (im_ack) begin
          if (redirect) begin
            state_next = IDLE;
          end else if (room) begin
            req_raw = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else if (redirect) begin
          state_next = DROP;
        end
      end
      DROP: begin
        if (im_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory interface outputs; no request may escape while reset is high.
  always_comb begin
    im_req  = req_raw & ~reset;
    im_addr = fetch_pc;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Fetch and outstanding-request addresses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[31:3], 3'b000};
    end else if (req_raw) begin
      req_pc   <= fetch_pc;
      fetch_pc <= fetch_pc + 32'd8;
    end
  end

  // FIFO pointers and occupancy; a redirect flushes ahead of push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      count <= count_next;
    end
  end

  // FIFO storage write; contents are only meaningful under count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[tail]  <= im_data;
      fifo_inst1[tail] <= im_data1;
      fifo_pc8[tail]   <= req_pc + 32'd8;
    end
  end

  // Head presentation; an empty queue reads as a NOP bubble.
  always_comb begin
    out_valid = (count != '0);
    out_inst  = out_valid ? fifo_inst[head]  : '0;
    out_inst1 = out_valid ? fifo_inst1[head] : '0;
    out_pc8   = out_valid ? fifo_pc8[head]   : '0;
  end

endmodule
